// File: rtl/dt_coeff_gen.sv
// dt_coeff_gen -- timing-coefficient generator for the covariance-prediction
// element units. One accepted start takes a double dt and produces
//   delta_t = dt, half_dt2 = dt^2/2, two3_dt3 = (2/3)dt^3, sixth_dt4 = dt^4/6
// using two shared fp_multiplier units sequenced by a small FSM.
//
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : request, only sampled in S_IDLE
//   dt_in       : time step, captured on an accepted start
//   delta_t     : captured dt (updates at acceptance)
//   half_dt2, two3_dt3, sixth_dt4 : coefficients, held until the next result
//   busy        : high from the cycle after acceptance until valid_out
//   valid_out   : one-cycle pulse, all four outputs valid
//
// fp_multiplier -- double-precision multiplier with a fixed latency of LAT
// cycles from the valid (go) pulse to the finish pulse. Operands must be held
// until finish. Round-to-nearest-even; subnormals flush to zero; inf/NaN
// propagate. No reset: a pulse in flight during reset still finishes.
//
// Ports: clk, valid (go), finish, a, b, result

module fp_multiplier #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        valid,
  output logic        finish,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result
);

  function automatic logic [63:0] fmul(input logic [63:0] x, input logic [63:0] y);
    logic               sgn, nan_x, nan_y, inf_x, inf_y, zro_x, zro_y;
    logic               g, s, rnd;
    logic [10:0]        ex, ey;
    logic [51:0]        fx, fy;
    logic [105:0]       p;
    logic [52:0]        m;
    logic [53:0]        mr;
    logic signed [13:0] e;
    logic [63:0]        r;
    sgn   = x[63] ^ y[63];
    ex    = x[62:52];
    ey    = y[62:52];
    fx    = x[51:0];
    fy    = y[51:0];
    nan_x = (ex == 11'h7FF) && (fx != 52'd0);
    nan_y = (ey == 11'h7FF) && (fy != 52'd0);
    inf_x = (ex == 11'h7FF) && (fx == 52'd0);
    inf_y = (ey == 11'h7FF) && (fy == 52'd0);
    zro_x = (ex == 11'd0);
    zro_y = (ey == 11'd0);
    p     = {53'd0, 1'b1, fx} * {53'd0, 1'b1, fy};
    e     = 14'(ex) + 14'(ey) - 14'sd1023;
    // product of two [1,2) significands lies in [1,4): pick the leading bit
    if (p[105]) begin
      m = p[105:53];
      g = p[52];
      s = |p[51:0];
      e = e + 14'sd1;
    end else begin
      m = p[104:52];
      g = p[51];
      s = |p[50:0];
    end
    rnd = g & (s | m[0]);
    mr  = {1'b0, m} + {53'd0, rnd};
    if (mr[53]) begin
      mr = {1'b0, mr[53:1]};
      e  = e + 14'sd1;
    end
    if (nan_x || nan_y || (inf_x && zro_y) || (zro_x && inf_y)) r = 64'h7FF8000000000000;
    else if (inf_x || inf_y)                                    r = {sgn, 11'h7FF, 52'd0};
    else if (zro_x || zro_y)                                    r = {sgn, 63'd0};
    else if (e > 14'sd2046)                                     r = {sgn, 11'h7FF, 52'd0};
    else if (e < 14'sd1)                                        r = {sgn, 63'd0};
    else                                                        r = {sgn, e[10:0], mr[51:0]};
    return r;
  endfunction

  logic [LAT:1] vld_pipe;
  logic [63:0]  r_res;

  always_ff @(posedge clk) begin
    vld_pipe[1] <= valid;
    for (int i = 2; i <= LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    r_res <= fmul(a, b);
  end

  assign finish = vld_pipe[LAT];
  assign result = r_res;

endmodule

module dt_coeff_gen #(
  parameter int                  DBL_WIDTH = 64,
  parameter logic [DBL_WIDTH-1:0] C_HALF    = 64'h3FE0000000000000,
  parameter logic [DBL_WIDTH-1:0] C_TWO3    = 64'h3FE5555555555555,
  parameter logic [DBL_WIDTH-1:0] C_SIXTH   = 64'h3FC5555555555555,
  parameter int                  MUL_LAT   = 4,
  parameter int                  MUL1_SKEW = 0   // extra latency of mul1 only
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DBL_WIDTH-1:0] dt_in,
  output logic [DBL_WIDTH-1:0] delta_t,
  output logic [DBL_WIDTH-1:0] half_dt2,
  output logic [DBL_WIDTH-1:0] two3_dt3,
  output logic [DBL_WIDTH-1:0] sixth_dt4,
  output logic                 busy,
  output logic                 valid_out
);

  typedef enum logic [2:0] {S_IDLE, S_SQ, S_P34, S_SC, S_SIX} state_t;

  state_t               r_state, w_state_n;
  logic                 w_adv;
  logic                 r_go0, r_go1, r_done0, r_done1;
  logic                 w_fin0, w_fin1_raw, w_fin1, w_ok0, w_ok1;
  logic [DBL_WIDTH-1:0] r_dt, r_dt2, r_dt3, r_dt4;
  logic [DBL_WIDTH-1:0] w_a0, w_b0, w_a1, w_b1, w_res0, w_res1;
  logic [DBL_WIDTH-1:0] r_delta, r_half, r_two3, r_sixth;
  logic                 r_busy, r_valid;

  fp_multiplier #(.LAT(MUL_LAT)) u_mul0 (
    .clk(clk), .valid(r_go0), .finish(w_fin0), .a(w_a0), .b(w_b0), .result(w_res0)
  );
  fp_multiplier #(.LAT(MUL_LAT + MUL1_SKEW)) u_mul1 (
    .clk(clk), .valid(r_go1), .finish(w_fin1_raw), .a(w_a1), .b(w_b1), .result(w_res1)
  );

  // Operands follow the state, so they stay stable from go until finish.
  always_comb begin
    w_a0 = r_dt;
    w_b0 = r_dt;
    w_a1 = r_dt2;
    w_b1 = r_dt2;
    case (r_state)
      S_P34: begin w_a0 = r_dt2;   w_b0 = r_dt;  end
      S_SC:  begin w_a0 = C_HALF;  w_b0 = r_dt2; w_a1 = C_TWO3; w_b1 = r_dt3; end
      S_SIX: begin w_a0 = C_SIXTH; w_b0 = r_dt4; end
      default: ;
    endcase
  end

  // mul1 only counts in stages that issued it; the done flags make finish
  // pulses that arrive in different cycles still complete the stage.
  assign w_fin1 = w_fin1_raw & ((r_state == S_P34) | (r_state == S_SC));
  assign w_ok0  = r_done0 | w_fin0;
  assign w_ok1  = r_done1 | w_fin1;

  always_comb begin
    w_state_n = r_state;
    w_adv     = 1'b0;
    case (r_state)
      S_IDLE: if (start)         begin w_adv = 1'b1; w_state_n = S_SQ;   end
      S_SQ:   if (w_ok0)         begin w_adv = 1'b1; w_state_n = S_P34;  end
      S_P34:  if (w_ok0 && w_ok1) begin w_adv = 1'b1; w_state_n = S_SC;  end
      S_SC:   if (w_ok0 && w_ok1) begin w_adv = 1'b1; w_state_n = S_SIX; end
      S_SIX:  if (w_ok0)         begin w_adv = 1'b1; w_state_n = S_IDLE; end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
    end else if (w_adv || r_state == S_IDLE) begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
    end else begin
      r_done0 <= w_ok0;
      r_done1 <= w_ok1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_go0   <= 1'b0;
      r_go1   <= 1'b0;
      r_dt    <= '0;
      r_dt2   <= '0;
      r_dt3   <= '0;
      r_dt4   <= '0;
      r_delta <= '0;
      r_half  <= '0;
      r_two3  <= '0;
      r_sixth <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_go0   <= 1'b0;
      r_go1   <= 1'b0;
      r_valid <= 1'b0;
      if (w_adv) begin
        case (r_state)
          S_IDLE: begin
            r_dt    <= dt_in;
            r_delta <= dt_in;
            r_busy  <= 1'b1;
            r_go0   <= 1'b1;
          end
          S_SQ: begin
            r_dt2 <= w_res0;
            r_go0 <= 1'b1;
            r_go1 <= 1'b1;
          end
          S_P34: begin
            r_dt3 <= w_res0;
            r_dt4 <= w_res1;
            r_go0 <= 1'b1;
            r_go1 <= 1'b1;
          end
          S_SC: begin
            r_half <= w_res0;
            r_two3 <= w_res1;
            r_go0  <= 1'b1;
          end
          S_SIX: begin
            r_sixth <= w_res0;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign delta_t   = r_delta;
  assign half_dt2  = r_half;
  assign two3_dt3  = r_two3;
  assign sixth_dt4 = r_sixth;
  assign busy      = r_busy;
  assign valid_out = r_valid;

endmodule

// File: doc/dt_coeff_gen.md
# dt_coeff_gen

Upstream timing-coefficient generator for the covariance-prediction CMU blocks. On each `start` it takes one IEEE-754 double `delta_t` and produces `delta_t`, `half_dt2` (dt²/2), `two3_dt3` ((2/3)·dt³) and `sixth_dt4` (dt⁴/6). These four values drive the time-parameter inputs of every CMU_PHi* element unit. It uses two shared `fp_multiplier` instances sequenced by an FSM, and no adders.

## Interface
- `DBL_WIDTH`, 64, operand/result width (IEEE-754 double)
- `C_HALF`, 64'h3FE0000000000000, constant 0.5
- `C_TWO3`, 64'h3FE5555555555555, constant 2/3
- `C_SIXTH`, 64'h3FC5555555555555, constant 1/6

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in S_IDLE
- `dt_in`  in  DBL_WIDTH  time step, captured on accepted `start`
- `delta_t`  out  DBL_WIDTH  registered copy of captured `dt_in`
- `half_dt2`  out  DBL_WIDTH  C_HALF·dt²
- `two3_dt3`  out  DBL_WIDTH  C_TWO3·dt³
- `sixth_dt4`  out  DBL_WIDTH  C_SIXTH·dt⁴
- `busy`  out  1  high from the cycle after an accepted `start` until `valid_out`
- `valid_out`  out  1  one-cycle pulse; all four outputs are valid and held

## Operation
- **Multipliers:** two `fp_multiplier` instances (ports `clk`, `valid`, `finish`, `a`, `b`, `result`).
  - `valid` (go) is a registered one-cycle pulse. Operands are held until that unit's `finish`.
- **Per-unit done flags:** each multiplier has a sticky done flag. A stage advances when every unit it issued has finished. `finish` pulses need not coincide; one unit's `finish` may arrive before the other's. Flags clear on each new issue.
- **FSM states:** S_IDLE → S_SQ → S_P34 → S_SC → S_SIX → S_IDLE.
  - S_IDLE: if `start`, latch `dt_in` to internal dt and to `delta_t`; set `busy`; issue mul0 = dt·dt; go to S_SQ. `start` while not in S_IDLE is ignored, with no queuing.
  - S_SQ: on mul0 finish, dt2 ← result; issue mul0 = dt2·dt and mul1 = dt2·dt2; go to S_P34.
  - S_P34: when both are done, dt3, dt4 ← results; issue mul0 = C_HALF·dt2 and mul1 = C_TWO3·dt3; go to S_SC.
  - S_SC: when both are done, `half_dt2`, `two3_dt3` ← results; issue mul0 = C_SIXTH·dt4; go to S_SIX.
  - S_SIX: on mul0 finish, `sixth_dt4` ← result; pulse `valid_out`; clear `busy`; go to S_IDLE.
- **Output hold:** outputs hold their last values until the next completed computation overwrites them.
  - `delta_t` updates at acceptance, which is before the other three outputs. Consumers sample all four on `valid_out` only.
- **Arithmetic:** no special-case logic. Zero, negative, inf and NaN propagate per `fp_multiplier`.
  - dt = 0 gives all-zero coefficients.
  - Negative dt gives negative `two3_dt3`; `half_dt2` and `sixth_dt4` stay positive.
- **Stray finish:** a `finish` pulse in S_IDLE, or from a unit not issued in the current stage, is ignored.

## Timing
- **Reset values:** all outputs are 0 and `busy`/`valid_out` are 0. State is S_IDLE; internal dt2/dt3/dt4 and done flags are 0.
- **Reset mid-operation:** the FSM returns to S_IDLE immediately and no `valid_out` is produced.
  - `fp_multiplier` has no reset. The integrator must not assert `start` within L+1 cycles of `rst_n` release, so a stale `finish` is absorbed in S_IDLE.
- **Latency:** let L be the number of cycles from go high to `finish` high.
  - First go is high the cycle after `start` is sampled.
  - `valid_out` is high 4L+5 cycles after the `start` sample cycle.
- **Throughput:** `start` is accepted in the cycle `valid_out` is high, because the FSM is already in S_IDLE. Back-to-back period is 4L+5 cycles.
- **`busy` timing:** `busy` rises the cycle after acceptance and falls with `valid_out` high.

## Test plan
- **Reset state:** assert `rst_n` low → all outputs 0, `busy`=0, `valid_out`=0; a `start` held during reset is not accepted.
- **dt = 1.0:** `dt_in`=64'h3FF0000000000000 → `delta_t`=64'h3FF0000000000000, `half_dt2`=64'h3FE0000000000000, `two3_dt3`=64'h3FE5555555555555, `sixth_dt4`=64'h3FC5555555555555.
  - `valid_out` is a single pulse exactly 4L+5 cycles after start.
- **dt = 2.0:** `dt_in`=64'h4000000000000000 → `half_dt2`=64'h4000000000000000; `two3_dt3` within 1 ulp of 64'h4015555555555555; `sixth_dt4` within 1 ulp of 64'h4005555555555555.
- **dt = −1.0 then 0.0 back-to-back:** second `start` asserted in the `valid_out` cycle.
  - First result: `two3_dt3`=64'hBFE5555555555555 and `half_dt2` positive.
  - Second computation is accepted immediately and yields all-zero coefficients.
- **Skewed finish and ignored start:** multiplier model finishes mul1 3 cycles after mul0 in S_P34/S_SC → results are still correct and advance waits for both. `start` pulses while `busy` are ignored: exactly one `valid_out` and the outputs match the first `dt_in`.
- **Reset mid-operation:** reset pulse in S_P34 → no `valid_out`; outputs are 0. A fresh start (after L+1 cycles) with dt=1.0 gives the correct results.
